seg7_scan_controller: RTL

- Time-multiplexed scan controller for an N-digit common-anode/cathode 7-segment display that shares one 3-bit-code segment decoder across all digits.
- Holds per-digit codes in shadow/active register banks, cycles a one-hot digit enable at a prescaled rate, and presents the selected digit's code to the shared decoder.
- Shadow-to-active updates are applied only at frame boundaries, so a displayed frame never tears.

---
 rtl/seg7_scan_controller_if.sv | 32 +++
 rtl/seg7_scan_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_controller_if.sv
// ============================================================================
// Module  : seg7_scan_controller_if
// Purpose : Shadow-bank write port and commit handshake for the 7-seg scanner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg7_scan_controller_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [2:0] wr_data;
    logic       commit;
    logic       commit_pending;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output commit,
        input  commit_pending
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  commit,
        output commit_pending
    );
endinterface

`default_nettype wire

// File: rtl/seg7_scan_controller.sv
// ============================================================================
// Module  : seg7_scan_controller
// Purpose : N-digit 7-segment scan controller with tear-free shadow/active
//           code banks; optional anti-ghosting blanking via the
//           SEG7_SCAN_DEADTIME_EN macro.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_controller #(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 1000,
    parameter int DEAD_CYCLES = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  enable,
    seg7_scan_controller_if.slave      bus,
    output logic [NUM_DIGITS-1:0]      digit_en,
    output logic [2:0]                 code_out,
    output logic                       frame_start
);

    localparam int c_cnt_w = $clog2(PRESCALE);
    localparam int c_idx_w = $clog2(NUM_DIGITS);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(PRESCALE - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    generate
        if ((NUM_DIGITS < 2) || (NUM_DIGITS > 8) || (PRESCALE < 4) ||
            (DEAD_CYCLES < 0) || (DEAD_CYCLES >= PRESCALE)) begin : g_bad_params
            $error("seg7_scan_controller: illegal parameter combination");
        end
    endgenerate

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_cnt_w-1:0]      r_count;
    logic [c_cnt_w-1:0]      w_count_nxt;
    logic [c_idx_w-1:0]      r_idx;
    logic [c_idx_w-1:0]      w_idx_nxt;
    logic [2:0]              r_shadow [NUM_DIGITS];
    logic [2:0]              r_active [NUM_DIGITS];
    logic [2:0]              w_active_nxt [NUM_DIGITS];
    logic                    r_pending;
    logic                    w_pending_nxt;
    logic [NUM_DIGITS-1:0]   w_en_nxt;
    logic [2:0]              w_code_nxt;
    logic                    w_fs_nxt;
    logic                    w_tick;
    logic                    w_boundary;
    logic                    w_apply;
    logic                    w_wr_ok;
    logic                    w_blank;

    assign w_tick     = (r_state == ST_SCAN) && (r_count == c_cnt_last);
    assign w_boundary = w_tick && (r_idx == c_idx_last);
    // A dark display has no frame to tear, so a pending copy goes through at once.
    assign w_apply    = r_pending && (w_boundary || !enable);
    assign w_wr_ok    = bus.wr_en && ({1'b0, bus.wr_addr} < 4'(NUM_DIGITS));

    assign bus.commit_pending = r_pending;

`ifdef SEG7_SCAN_DEADTIME_EN
    localparam logic [c_cnt_w-1:0] c_dead = c_cnt_w'(DEAD_CYCLES);
    assign w_blank = (w_count_nxt < c_dead);
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_idx_nxt     = r_idx;
        w_fs_nxt      = 1'b0;
        w_active_nxt  = r_active;
        // A commit arriving while already pending (or on the applying edge) is absorbed.
        w_pending_nxt = r_pending ? !w_apply : bus.commit;
        if (w_apply) begin
            w_active_nxt = r_shadow;
        end

        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
            w_idx_nxt   = '0;
        end else if (r_state == ST_IDLE) begin
            w_state_nxt = ST_SCAN;
            w_count_nxt = '0;
            w_idx_nxt   = '0;
            w_fs_nxt    = 1'b1;
        end else if (w_tick) begin
            w_count_nxt = '0;
            w_idx_nxt   = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            w_fs_nxt    = (r_idx == c_idx_last);
        end else begin
            w_count_nxt = r_count + 1'b1;
        end

        w_en_nxt   = '0;
        w_code_nxt = 3'd0;
        if (enable) begin
            w_en_nxt[w_idx_nxt] = 1'b1;
            w_code_nxt          = w_active_nxt[w_idx_nxt];
        end
        if (w_blank) begin
            w_en_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_idx       <= '0;
            r_pending   <= 1'b0;
            digit_en    <= '0;
            code_out    <= 3'd0;
            frame_start <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= 3'd0;
                r_active[i] <= 3'd0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_idx       <= w_idx_nxt;
            r_pending   <= w_pending_nxt;
            digit_en    <= w_en_nxt;
            code_out    <= w_code_nxt;
            frame_start <= w_fs_nxt;
            r_active    <= w_active_nxt;
            // Copy above reads pre-write shadow; a same-edge write lands in shadow only.
            if (w_wr_ok) begin
                r_shadow[bus.wr_addr[c_idx_w-1:0]] <= bus.wr_data;
            end
        end
    end

endmodule

`default_nettype wire
